// File: rtl/uart_rx_os16_pkg.sv
// Shared constants, state encoding and divider helper for the 16x-oversampling UART receiver.
package uart_rx_os16_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

    localparam logic [3:0] TCNT_MID  = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] TCNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIDX_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_os16_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable to phase-align to a start edge.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Next count and registered tick (high while the count sits at DIV-1).
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = (cnt_d == CNT_LAST);
    end

    // Counter and tick registers.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT_ZERO;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling, start-glitch rejection, framing-error and overrun flags.
module uart_rx_os16
    import uart_rx_os16_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic       rdy,
    output logic [7:0] dout,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);

    logic                 rx_meta_q;
    logic                 rx_s_q;
    rx_state_e            state_q, state_d;
    logic [3:0]           tcnt_q, tcnt_d;
    logic [2:0]           bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 rdy_q, rdy_d;
    logic [7:0]           dout_q, dout_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 restart_s;
    logic                 tick_s;
    logic                 good_s;
    logic                 bad_s;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Two-flop synchronizer for the asynchronous rx pin; idles high.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame sequencing: tick counting, bit sampling and completion detection.
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bidx_d    = bidx_q;
        shift_d   = shift_q;
        restart_s = 1'b0;
        good_s    = 1'b0;
        bad_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d   = ST_START;
                    tcnt_d    = 4'd0;
                    bidx_d    = 3'd0;
                    restart_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (tcnt_q == TCNT_MID)) begin
                    // A start bit that is high again at its centre was only a glitch.
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        tcnt_d  = 4'd0;
                        state_d = ST_DATA;
                    end
                end else if (tick_s) begin
                    tcnt_d = tcnt_q + 4'd1;
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            ST_DATA: begin
                if (tick_s && (tcnt_q == TCNT_LAST)) begin
                    shift_d[bidx_q] = rx_s_q;
                    tcnt_d          = 4'd0;
                    if (bidx_q == BIDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end else if (tick_s) begin
                    tcnt_d = tcnt_q + 4'd1;
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            ST_STOP: begin
                if (tick_s && (tcnt_q == TCNT_LAST)) begin
                    if (rx_s_q) begin
                        good_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        bad_s   = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else if (tick_s) begin
                    tcnt_d = tcnt_q + 4'd1;
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            ST_BREAK: begin
                // Hold here until the line returns high so a long break cannot retrigger.
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output flags; a good completion takes priority over a same-cycle rdy_clr.
    always_comb begin
        rdy_d       = rdy_q;
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (good_s) begin
            rdy_d       = 1'b1;
            dout_d      = shift_q;
            frame_err_d = 1'b0;
            if (rdy_clr) begin
                overrun_d = 1'b0;
            end else if (rdy_q) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (rdy_clr) begin
            rdy_d       = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = bad_s ? 1'b1 : frame_err_q;
        end else if (bad_s) begin
            frame_err_d = 1'b1;
        end else begin
            rdy_d = rdy_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= 4'd0;
            bidx_q      <= 3'd0;
            shift_q     <= {DATA_BITS{1'b0}};
            rdy_q       <= 1'b0;
            dout_q      <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bidx_q      <= bidx_d;
            shift_q     <= shift_d;
            rdy_q       <= rdy_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rdy       = rdy_q;
    assign dout      = dout_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16 at 64 clocks per bit, checked against a frame-level model.
module tb_uart_rx_os16;

    logic       clk_50m;
    logic       rst_n;
    logic       rx;
    logic       rdy_clr;
    logic       rdy;
    logic [7:0] dout;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    // Frame-level model of the consumer-visible outputs.
    logic       m_rdy;
    logic [7:0] m_dout;
    logic       m_ferr;
    logic       m_ovr;

    logic [10:0] obs;
    logic [10:0] exp_v;

    uart_rx_os16 #(.CLK_HZ(6400), .BAUD(100)) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .rx        (rx),
        .rdy_clr   (rdy_clr),
        .rdy       (rdy),
        .dout      (dout),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk_50m = 1'b0;
    always #5 clk_50m = ~clk_50m;

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation exceeded 150000 cycles");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_rdy = 1'b0; m_dout = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
    endfunction

    function automatic void model_good(input logic [7:0] b);
        if (m_rdy) m_ovr = 1'b1;
        m_rdy  = 1'b1;
        m_dout = b;
        m_ferr = 1'b0;
    endfunction

    function automatic void model_bad();
        m_ferr = 1'b1;
    endfunction

    function automatic void model_clr();
        m_rdy = 1'b0;
        m_ovr = 1'b0;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop, input int period);
        @(posedge clk_50m); #1;
        rx = 1'b0;
        repeat (period) @(posedge clk_50m);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (period) @(posedge clk_50m);
        end
        #1 rx = stop;
        repeat (period) @(posedge clk_50m);
    endtask

    task automatic pulse_clr();
        @(posedge clk_50m); #1;
        rdy_clr = 1'b1;
        @(posedge clk_50m); #1;
        rdy_clr = 1'b0;
        model_clr();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx = 1'b1; rdy_clr = 1'b0;
        model_reset();
        repeat (5) @(posedge clk_50m);
        #1 rst_n = 1'b1;
        @(negedge clk_50m);
        obs = {rdy, overrun, frame_err, dout};
        exp_v = 11'd0;
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset: got %h expected %h", obs, exp_v);
        end
        repeat (20) @(posedge clk_50m);
    endtask

    task automatic test_basic();
        int lat;
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 64);
            begin
                while (rdy !== 1'b1 && lat < 800) begin
                    @(posedge clk_50m); #1;
                    lat++;
                end
            end
        join
        checks++;
        if (lat < 600 || lat > 625) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected 600..625", lat);
        end
        model_good(8'hA5);
        @(negedge clk_50m);
        obs = {rdy, overrun, frame_err, dout};
        exp_v = {m_rdy, m_ovr, m_ferr, m_dout};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL basic_a5: got %h expected %h", obs, exp_v);
        end
        pulse_clr();
        @(negedge clk_50m);
        checks++;
        if (rdy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL basic_clr: got rdy=%b ovr=%b expected 0 0", rdy, overrun);
        end
    endtask

    task automatic test_glitch();
        @(posedge clk_50m); #1 rx = 1'b0;
        repeat (20) @(posedge clk_50m);
        #1 rx = 1'b1;
        repeat (100) @(posedge clk_50m);
        @(negedge clk_50m);
        obs = {rdy, overrun, frame_err, dout};
        exp_v = {m_rdy, m_ovr, m_ferr, m_dout};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL glitch: got %h expected %h", obs, exp_v);
        end
        send_frame(8'h3C, 1'b1, 64);
        model_good(8'h3C);
        @(negedge clk_50m);
        obs = {rdy, overrun, frame_err, dout};
        exp_v = {m_rdy, m_ovr, m_ferr, m_dout};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL after_glitch_3c: got %h expected %h", obs, exp_v);
        end
        pulse_clr();
        repeat (10) @(posedge clk_50m);
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 1'b0, 64);
        repeat (200) @(posedge clk_50m);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk_50m);
        model_bad();
        @(negedge clk_50m);
        obs = {rdy, overrun, frame_err, dout};
        exp_v = {m_rdy, m_ovr, m_ferr, m_dout};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL frame_err_55: got %h expected %h", obs, exp_v);
        end
        send_frame(8'h0F, 1'b1, 64);
        model_good(8'h0F);
        @(negedge clk_50m);
        obs = {rdy, overrun, frame_err, dout};
        exp_v = {m_rdy, m_ovr, m_ferr, m_dout};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL recover_0f: got %h expected %h", obs, exp_v);
        end
        pulse_clr();
        repeat (10) @(posedge clk_50m);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, 64);
        model_good(8'h11);
        send_frame(8'h22, 1'b1, 64);
        model_good(8'h22);
        @(negedge clk_50m);
        obs = {rdy, overrun, frame_err, dout};
        exp_v = {m_rdy, m_ovr, m_ferr, m_dout};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL overrun_22: got %h expected %h", obs, exp_v);
        end
        pulse_clr();
        @(negedge clk_50m);
        obs = {rdy, overrun, frame_err, dout};
        exp_v = {m_rdy, m_ovr, m_ferr, m_dout};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL overrun_clr: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_sweep(input int period, input int count);
        logic [7:0] b;
        int         wait_cnt;
        for (int i = 0; i < count; i++) begin
            if (i == 0)      b = 8'h00;
            else if (i == 1) b = 8'hFF;
            else             b = 8'($urandom);
            send_frame(b, 1'b1, period);
            wait_cnt = 0;
            while (rdy !== 1'b1 && wait_cnt < 100) begin
                @(posedge clk_50m); #1;
                wait_cnt++;
            end
            model_good(b);
            @(negedge clk_50m);
            obs = {rdy, overrun, frame_err, dout};
            exp_v = {m_rdy, m_ovr, m_ferr, m_dout};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL sweep_p%0d_%02h: got %h expected %h", period, b, obs, exp_v);
            end
            repeat (2) @(posedge clk_50m);
            pulse_clr();
            repeat ($urandom_range(0, 8)) @(posedge clk_50m);
        end
    endtask

    task automatic test_reset_mid();
        fork
            send_frame(8'hF0, 1'b1, 64);
            begin
                repeat (64 * 5 + 20) @(posedge clk_50m);
                #1 rst_n = 1'b0;
                repeat (30) @(posedge clk_50m);
                #1 rst_n = 1'b1;
                model_reset();
                @(negedge clk_50m);
                obs = {rdy, overrun, frame_err, dout};
                exp_v = 11'd0;
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL reset_mid: got %h expected %h", obs, exp_v);
                end
            end
        join
        repeat (1000) @(posedge clk_50m);
        @(negedge clk_50m);
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL partial_frame: got rdy=%b expected 0", rdy);
        end
        send_frame(8'h81, 1'b1, 64);
        model_good(8'h81);
        @(negedge clk_50m);
        obs = {rdy, overrun, frame_err, dout};
        exp_v = {m_rdy, m_ovr, m_ferr, m_dout};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL after_reset_81: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_sweep(64, 32);
        test_sweep(62, 16);
        test_sweep(66, 16);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
